multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle RV32I core. It sequences fetch, decode, execute, memory and writeback for each instruction, and drives every datapath enable and mux select. It also drives the `immSrc` select of the immediate extender, and handshakes with a single shared instruction/data memory port.

---
 rtl/multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Main control FSM of the multicycle RV32I core. Sequences fetch, decode,
//   execute, memory and writeback for every instruction, drives the datapath
//   enables and mux selects, the immediate-format select, and the request
//   side of the shared instruction/data memory port.
//
//   Memory handshake: memReq (with adrSrc/memWrite) is raised in a request
//   state and held unchanged until the cycle in which memReady is high; that
//   cycle completes the access and the FSM leaves the request state on the
//   following edge. memReady outside a request state has no effect.
//
// Ports
//   clk        core clock, rising edge
//   rst_n      asynchronous active-low reset; forces every output to 0
//   op         IR[6:0] opcode
//   funct3     IR[14:12]
//   zero       ALU zero flag (combinational)
//   memReady   memory completes the current access this cycle
//   memReq     memory access request
//   memWrite   access is a write (meaningful only with memReq)
//   adrSrc     memory address: 0 = PC, 1 = ALU-out register
//   irWrite    load IR and oldPC
//   pcWrite    load PC from result
//   regWrite   register-file write
//   resultSrc  00 = ALU-out reg, 01 = memory data reg, 10 = ALU result
//   aluSrcA    00 = PC, 01 = oldPC, 10 = rs1, 11 = zero
//   aluSrcB    00 = rs2, 01 = immediate, 10 = constant 4
//   aluOp      00 = add, 01 = sub, 10 = decode from funct3/funct7
//   immSrc     000 = I, 001 = S, 010 = B, 011 = J, 100 = U
//   illegal    core is trapped
//   state_o    current FSM state (debug observation only)

module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       memReady,
    output logic       memReq,
    output logic       memWrite,
    output logic       adrSrc,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [2:0] immSrc,
    output logic       illegal,
    output logic [3:0] state_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXER     = 4'd6,
        S_EXEI     = 4'd7,
        S_LUI      = 4'd8,
        S_AUIPC    = 4'd9,
        S_JALR     = 4'd10,
        S_JAL      = 4'd11,
        S_ALUWB    = 4'd12,
        S_BRANCH   = 4'd13,
        S_TRAP     = 4'd14
    } state_e;

    state_e state_q;

    assign state_o = state_q;

    // Only BEQ (000) and BNE (001) are implemented.
    logic branch_ok;
    assign branch_ok = (funct3 == 3'b000) || (funct3 == 3'b001);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:    if (memReady) state_q <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state_q <= S_MEMADR;
                        OP_R:              state_q <= S_EXER;
                        OP_IMM:            state_q <= S_EXEI;
                        OP_BRANCH:         state_q <= branch_ok ? S_BRANCH : S_TRAP;
                        OP_JAL:            state_q <= S_JAL;
                        OP_JALR:           state_q <= S_JALR;
                        OP_LUI:            state_q <= S_LUI;
                        OP_AUIPC:          state_q <= S_AUIPC;
                        default:           state_q <= S_TRAP;
                    endcase
                end
                // Only load/store reach MEMADR, so anything not a store is a load.
                S_MEMADR:   state_q <= (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (memReady) state_q <= S_MEMWB;
                S_MEMWB:    state_q <= S_FETCH;
                S_MEMWRITE: if (memReady) state_q <= S_FETCH;
                S_EXER:     state_q <= S_ALUWB;
                S_EXEI:     state_q <= S_ALUWB;
                S_LUI:      state_q <= S_ALUWB;
                S_AUIPC:    state_q <= S_ALUWB;
                // JALR computes rs1+imm as the target, then shares JAL's
                // PC-load / link-compute step.
                S_JALR:     state_q <= S_JAL;
                S_JAL:      state_q <= S_ALUWB;
                S_ALUWB:    state_q <= S_FETCH;
                S_BRANCH:   state_q <= S_FETCH;
                S_TRAP:     state_q <= S_TRAP;
                default:    state_q <= S_TRAP;
            endcase
        end
    end

    // Output decode. Moore terms come from state_q; the FETCH enables
    // (memReady) and the BRANCH pcWrite (zero) are Mealy terms. Everything is
    // gated by rst_n so enables drop the moment reset is asserted, not at the
    // next edge.
    always_comb begin
        memReq    = 1'b0;
        memWrite  = 1'b0;
        adrSrc    = 1'b0;
        irWrite   = 1'b0;
        pcWrite   = 1'b0;
        regWrite  = 1'b0;
        resultSrc = 2'b00;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        aluOp     = 2'b00;
        illegal   = 1'b0;

        case (op)
            OP_LOAD, OP_IMM, OP_JALR: immSrc = 3'b000;
            OP_STORE:                 immSrc = 3'b001;
            OP_BRANCH:                immSrc = 3'b010;
            OP_JAL:                   immSrc = 3'b011;
            OP_LUI, OP_AUIPC:         immSrc = 3'b100;
            default:                  immSrc = 3'b000;
        endcase

        case (state_q)
            S_FETCH: begin
                memReq    = 1'b1;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                irWrite   = memReady;
                pcWrite   = memReady;
            end
            S_DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
            end
            S_MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            S_MEMREAD: begin
                memReq = 1'b1;
                adrSrc = 1'b1;
            end
            S_MEMWB: begin
                resultSrc = 2'b01;
                regWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                memReq   = 1'b1;
                memWrite = 1'b1;
                adrSrc   = 1'b1;
            end
            S_EXER: begin
                aluSrcA = 2'b10;
                aluOp   = 2'b10;
            end
            S_EXEI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                aluOp   = 2'b10;
            end
            S_LUI: begin
                aluSrcA = 2'b11;
                aluSrcB = 2'b01;
            end
            S_AUIPC: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
            end
            S_JALR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            S_JAL: begin
                // PC <= target held in ALU-out; ALU computes oldPC+4 for rd.
                aluSrcA = 2'b01;
                aluSrcB = 2'b10;
                pcWrite = 1'b1;
            end
            S_ALUWB: begin
                regWrite = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA = 2'b10;
                aluOp   = 2'b01;
                pcWrite = (funct3 == 3'b001) ? !zero : zero;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: ;
        endcase

        if (!rst_n) begin
            memReq    = 1'b0;
            memWrite  = 1'b0;
            adrSrc    = 1'b0;
            irWrite   = 1'b0;
            pcWrite   = 1'b0;
            regWrite  = 1'b0;
            resultSrc = 2'b00;
            aluSrcA   = 2'b00;
            aluSrcB   = 2'b00;
            aluOp     = 2'b00;
            immSrc    = 3'b000;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. The driver walks each instruction through its
// architectural step list (fetch with waits, decode, execute/memory steps,
// writeback), pushing the full expected output vector for every cycle into
// exp_q; the monitor pops one entry per cycle at the falling edge and
// compares. Output vector packing:
//   {memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite,
//    resultSrc[1:0], aluSrcA[1:0], aluSrcB[1:0], aluOp[1:0], immSrc[2:0], illegal}

module tb_multicycle_ctrl;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] ITYPE  = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       zero = 1'b0;
    logic       memReady = 1'b0;
    logic       memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, illegal;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp;
    logic [2:0] immSrc;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
        .memReady(memReady), .memReq(memReq), .memWrite(memWrite),
        .adrSrc(adrSrc), .irWrite(irWrite), .pcWrite(pcWrite),
        .regWrite(regWrite), .resultSrc(resultSrc), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluOp(aluOp), .immSrc(immSrc),
        .illegal(illegal), .state_o(state_o)
    );

    logic [17:0] act;
    assign act = {memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite,
                  resultSrc, aluSrcA, aluSrcB, aluOp, immSrc, illegal};

    // ---------------- scoreboard state ----------------
    logic [17:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cycle_no = 0;
    string       cur_name = "reset";
    logic [6:0]  cur_op = 7'd0;
    logic        in_reset = 1'b1;

    task automatic chk(input string name, input logic [17:0] a, input logic [17:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s cycle %0d: got %05h expected %05h", name, cycle_no, a, x);
        end
    endtask

    // Immediate format table for an opcode.
    function automatic logic [2:0] ref_imm(input logic [6:0] o);
        if (o == LOAD || o == ITYPE || o == JALR) return 3'b000;
        if (o == STORE)                           return 3'b001;
        if (o == BRANCH)                          return 3'b010;
        if (o == JAL)                             return 3'b011;
        if (o == LUI || o == AUIPC)               return 3'b100;
        return 3'b000;
    endfunction

    // Expected vector for one cycle outside reset; immSrc follows the held opcode.
    function automatic logic [17:0] e(input logic mreq, input logic mwr, input logic adr,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic [1:0] res, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] aop,
                                      input logic ill);
        return {mreq, mwr, adr, irw, pcw, rw, res, a, b, aop, ref_imm(cur_op), ill};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        cycle_no++;
        if (exp_q.size() > 0) chk(cur_name, act, exp_q.pop_front());
    end

    // ---------------- driver tasks ----------------
    // Entry and exit point: 1 time unit after a rising edge.
    task automatic cyc(input logic rdy, input logic z, input logic [17:0] x);
        memReady = rdy;
        zero     = z;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic reset_pulse(input int n);
        rst_n = 1'b0;
        #1;
        chk("reset_async_drop", act, 18'd0);
        for (int i = 0; i < n; i++) cyc(rb(), rb(), 18'd0);
        rst_n = 1'b1;
    endtask

    task automatic fetch(input int wf);
        for (int i = 0; i < wf; i++) cyc(1'b0, rb(), e(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0));
        cyc(1'b1, rb(), e(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,0));
    endtask

    task automatic mem_wait(input int wm, input logic wr);
        for (int i = 0; i < wm; i++) cyc(1'b0, rb(), e(1,wr,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0));
        cyc(1'b1, rb(), e(1,wr,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0));
    endtask

    task automatic aluwb();
        cyc(rb(), rb(), e(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0));
    endtask

    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f,
                             input int wf, input int wm);
        logic z;
        cur_name = name;
        cur_op   = o;
        op       = o;
        funct3   = f;
        fetch(wf);
        cyc(rb(), rb(), e(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0));           // decode
        if (o == LOAD) begin
            cyc(rb(), rb(), e(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0));
            mem_wait(wm, 1'b0);
            cyc(rb(), rb(), e(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,0));
        end else if (o == STORE) begin
            cyc(rb(), rb(), e(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0));
            mem_wait(wm, 1'b1);
        end else if (o == RTYPE) begin
            cyc(rb(), rb(), e(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0));
            aluwb();
        end else if (o == ITYPE) begin
            cyc(rb(), rb(), e(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,0));
            aluwb();
        end else if (o == LUI) begin
            cyc(rb(), rb(), e(0,0,0,0,0,0,2'b00,2'b11,2'b01,2'b00,0));
            aluwb();
        end else if (o == AUIPC) begin
            cyc(rb(), rb(), e(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0));
            aluwb();
        end else if (o == JALR || o == JAL) begin
            if (o == JALR) cyc(rb(), rb(), e(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0));
            cyc(rb(), rb(), e(0,0,0,0,1,0,2'b00,2'b01,2'b10,2'b00,0));
            aluwb();
        end else if (o == BRANCH && f <= 3'd1) begin
            z = rb();
            // BEQ takes the branch on equal (zero), BNE on not-equal.
            cyc(rb(), z, e(0,0,0,0,(f == 3'd0) ? z : !z,0,2'b00,2'b10,2'b00,2'b01,0));
        end else begin
            cur_name = {name, "_trap"};
            for (int i = 0; i < 20; i++) cyc(rb(), rb(), e(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1));
            cur_name = {name, "_reset"};
            reset_pulse(2);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [6:0] legal_ops[9] = '{LOAD, STORE, RTYPE, ITYPE, BRANCH, JAL, JALR, LUI, AUIPC};

    initial begin
        logic [6:0] o;
        logic [2:0] f;
        @(posedge clk);
        #1;
        // All outputs 0 while held in reset.
        chk("reset_hold", act, 18'd0);
        cyc(rb(), rb(), 18'd0);
        cyc(rb(), rb(), 18'd0);
        rst_n = 1'b1;

        run_instr("rtype_add", RTYPE, 3'd0, 0, 0);
        run_instr("load_wait", LOAD, 3'd2, 2, 2);
        run_instr("beq", BRANCH, 3'd0, 0, 0);
        run_instr("beq", BRANCH, 3'd0, 1, 0);
        run_instr("bne", BRANCH, 3'd1, 0, 0);
        run_instr("bne", BRANCH, 3'd1, 0, 0);
        run_instr("jalr", JALR, 3'd0, 0, 0);
        run_instr("jal", JAL, 3'd5, 0, 0);
        run_instr("lui", LUI, 3'd0, 0, 0);
        run_instr("auipc", AUIPC, 3'd0, 1, 0);
        run_instr("store", STORE, 3'd0, 0, 3);
        run_instr("illegal_op0", 7'd0, 3'd0, 0, 0);
        run_instr("after_reset", ITYPE, 3'd0, 0, 0);
        run_instr("illegal_br", BRANCH, 3'd2, 1, 0);
        run_instr("after_reset", RTYPE, 3'd0, 0, 0);

        // Reset mid-MEMWRITE while the request is outstanding.
        cur_name = "store_abort";
        cur_op = STORE; op = STORE; funct3 = 3'd2;
        fetch(0);
        cyc(rb(), rb(), e(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0));
        cyc(rb(), rb(), e(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0));
        cyc(1'b0, rb(), e(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0));
        cyc(1'b0, rb(), e(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0));
        reset_pulse(2);
        // Fresh fetch right after release: memReq=1, adrSrc=0.
        run_instr("post_abort", LOAD, 3'd2, 1, 0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                do o = 7'($urandom_range(0, 127));
                while (o inside {LOAD, STORE, RTYPE, ITYPE, BRANCH, JAL, JALR, LUI, AUIPC});
            end else begin
                o = legal_ops[$urandom_range(0, 8)];
            end
            f = 3'($urandom_range(0, 7));
            if (o == BRANCH && $urandom_range(0, 9) != 0) f = 3'($urandom_range(0, 1));
            run_instr("random", o, f, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        cur_name = "drain";
        repeat (2) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
